// File: rtl/volume_display.sv
// Binary-to-BCD volume display driver: double-dabble conversion, 4x 7-segment.
// Optional LEADING_ZERO_BLANK_EN blanks zero digits above the highest nonzero one.
module volume_display #(
    parameter int BIT_COUNT   = 14,
    parameter int DIGIT_COUNT = 4
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [BIT_COUNT-1:0] value,
    input  logic                 value_valid,
    output logic                 busy,
    output logic                 overflow,
    output logic [6:0]           hex0,
    output logic [6:0]           hex1,
    output logic [6:0]           hex2,
    output logic [6:0]           hex3
);

    localparam int BW   = 4 * DIGIT_COUNT;
    localparam int CW   = $clog2(BIT_COUNT + 1);
    localparam int NSEG = (DIGIT_COUNT > 4) ? DIGIT_COUNT : 4;

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] CONVERT = 2'd1;
    localparam logic [1:0] UPDATE  = 2'd2;

    localparam logic [6:0] SEG_0 = 7'h40;
    localparam logic [6:0] BLANK = 7'h7F;
    localparam logic [6:0] DASH  = 7'h3F;
`ifdef LEADING_ZERO_BLANK_EN
    localparam logic [6:0] LZ_SEG = BLANK;
    localparam bit LZ_BLANK = 1'b1;
`else
    localparam logic [6:0] LZ_SEG = SEG_0;
    localparam bit LZ_BLANK = 1'b0;
`endif

    function automatic logic [63:0] pow10(input int n);
        logic [63:0] r;
        r = 64'd1;
        for (int i = 0; i < n; i++) r = r * 64'd10;
        return r;
    endfunction

    localparam logic [63:0] MAX_VAL = pow10(DIGIT_COUNT) - 64'd1;

    function automatic logic [6:0] seg7(input logic [3:0] d);
        logic [6:0] s;
        unique case (d)
            4'd0:    s = 7'h40;
            4'd1:    s = 7'h79;
            4'd2:    s = 7'h24;
            4'd3:    s = 7'h30;
            4'd4:    s = 7'h19;
            4'd5:    s = 7'h12;
            4'd6:    s = 7'h02;
            4'd7:    s = 7'h78;
            4'd8:    s = 7'h00;
            4'd9:    s = 7'h10;
            default: s = BLANK;
        endcase
        return s;
    endfunction

    logic [1:0]           state_q, state_d;
    logic [BIT_COUNT-1:0] bin_q, bin_d;
    logic [BW-1:0]        bcd_q, bcd_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 busy_q, busy_d;
    logic                 cap_ovf_q, cap_ovf_d;
    logic                 ovf_q, ovf_d;
    logic [6:0]           hex_q [4];
    logic [6:0]           hex_d [4];
    logic [BW-1:0]        bcd_adj;
    logic [6:0]           digseg [NSEG];
    logic                 seen;

    // Double-dabble correction: add 3 to every nibble of 5 or more
    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < DIGIT_COUNT; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5)
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
        end
    end

    // Segment codes for the finished BCD result, with optional leading blanking
    always_comb begin
        seen = 1'b0;
        for (int k = 0; k < NSEG; k++) digseg[k] = BLANK;
        for (int i = DIGIT_COUNT - 1; i >= 0; i--) begin
            if (bcd_q[4*i +: 4] != 4'd0) seen = 1'b1;
            if (LZ_BLANK && !seen && i != 0)
                digseg[i] = BLANK;
            else
                digseg[i] = seg7(bcd_q[4*i +: 4]);
        end
    end

    // FSM and datapath next-state
    always_comb begin
        state_d   = state_q;
        bin_d     = bin_q;
        bcd_d     = bcd_q;
        cnt_d     = cnt_q;
        busy_d    = busy_q;
        cap_ovf_d = cap_ovf_q;
        ovf_d     = ovf_q;
        for (int k = 0; k < 4; k++) hex_d[k] = hex_q[k];
        unique case (state_q)
            IDLE: begin
                if (value_valid) begin
                    bin_d     = value;
                    bcd_d     = '0;
                    cnt_d     = CW'(BIT_COUNT);
                    busy_d    = 1'b1;
                    cap_ovf_d = 64'(value) > MAX_VAL;
                    state_d   = CONVERT;
                end
            end
            CONVERT: begin
                bcd_d = {bcd_adj[BW-2:0], bin_q[BIT_COUNT-1]};
                bin_d = bin_q << 1;
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) state_d = UPDATE;
            end
            UPDATE: begin
                for (int k = 0; k < 4; k++)
                    hex_d[k] = cap_ovf_q ? DASH : digseg[k];
                ovf_d   = cap_ovf_q;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // State registers; reset shows the value 0
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            bin_q     <= '0;
            bcd_q     <= '0;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            cap_ovf_q <= 1'b0;
            ovf_q     <= 1'b0;
            for (int k = 0; k < 4; k++)
                hex_q[k] <= (k == 0) ? SEG_0 :
                            (k < DIGIT_COUNT) ? LZ_SEG : BLANK;
        end else begin
            state_q   <= state_d;
            bin_q     <= bin_d;
            bcd_q     <= bcd_d;
            cnt_q     <= cnt_d;
            busy_q    <= busy_d;
            cap_ovf_q <= cap_ovf_d;
            ovf_q     <= ovf_d;
            for (int k = 0; k < 4; k++) hex_q[k] <= hex_d[k];
        end
    end

    assign busy     = busy_q;
    assign overflow = ovf_q;
    assign hex0     = hex_q[0];
    assign hex1     = hex_q[1];
    assign hex2     = hex_q[2];
    assign hex3     = hex_q[3];

endmodule

// File: tb/tb_volume_display.sv
// Directed self-checking bench for volume_display.
// Expected leading-digit codes follow LEADING_ZERO_BLANK_EN.
module tb_volume_display;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [13:0] value = '0;
    logic        value_valid = 1'b0;
    logic        busy, overflow;
    logic [6:0]  hex0, hex1, hex2, hex3;

    int errors = 0;
    int checks = 0;

`ifdef LEADING_ZERO_BLANK_EN
    localparam logic [6:0] LZ = 7'h7F;
`else
    localparam logic [6:0] LZ = 7'h40;
`endif

    volume_display #(.BIT_COUNT(14), .DIGIT_COUNT(4)) dut (
        .clock(clock), .reset(reset), .value(value),
        .value_valid(value_valid), .busy(busy), .overflow(overflow),
        .hex0(hex0), .hex1(hex1), .hex2(hex2), .hex3(hex3)
    );

    always #5 clock = ~clock;

    task automatic strobe(input logic [13:0] v, output int cyc);
        @(posedge clock); #1;
        value = v; value_valid = 1'b1;
        @(posedge clock); #1;
        value_valid = 1'b0;
        cyc = 0;
        while (busy === 1'b1 && cyc < 100) begin
            @(posedge clock); #1;
            cyc++;
        end
    endtask

    task automatic test_reset;
        reset = 1'b0;
        #12;
        @(negedge clock) reset = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        checks++;
        if (hex0 !== 7'h40) begin errors++;
            $display("FAIL reset_hex0 got %h exp %h", hex0, 7'h40); end
        checks++;
        if ({hex3, hex2, hex1} !== {LZ, LZ, LZ}) begin errors++;
            $display("FAIL reset_hex321 got %h %h %h exp %h", hex3, hex2, hex1, LZ); end
        checks++;
        if (busy !== 1'b0 || overflow !== 1'b0) begin errors++;
            $display("FAIL reset_flags got busy=%b ovf=%b exp 0 0", busy, overflow); end
    endtask

    task automatic test_1234;
        int cyc, hold_bad;
        hold_bad = 0;
        @(posedge clock); #1;
        value = 14'd1234; value_valid = 1'b1;
        @(posedge clock); #1;
        value_valid = 1'b0;
        cyc = 0;
        while (busy === 1'b1 && cyc < 100) begin
            if (hex0 !== 7'h40) hold_bad++;
            @(posedge clock); #1;
            cyc++;
        end
        checks++;
        if (cyc != 15) begin errors++;
            $display("FAIL busy_len_1234 got %0d exp 15", cyc); end
        checks++;
        if (hold_bad != 0) begin errors++;
            $display("FAIL hold_during_convert got %0d changes exp 0", hold_bad); end
        checks++;
        if ({hex3, hex2, hex1, hex0} !== {7'h79, 7'h24, 7'h30, 7'h19}) begin errors++;
            $display("FAIL disp_1234 got %h %h %h %h exp 79 24 30 19",
                     hex3, hex2, hex1, hex0); end
        checks++;
        if (overflow !== 1'b0) begin errors++;
            $display("FAIL ovf_1234 got %b exp 0", overflow); end
    endtask

    task automatic test_zero;
        int cyc;
        strobe(14'd0, cyc);
        checks++;
        if ({hex3, hex2, hex1, hex0} !== {LZ, LZ, LZ, 7'h40}) begin errors++;
            $display("FAIL disp_0 got %h %h %h %h exp %h %h %h 40",
                     hex3, hex2, hex1, hex0, LZ, LZ, LZ); end
    endtask

    task automatic test_overflow;
        int cyc;
        strobe(14'd9999, cyc);
        checks++;
        if ({hex3, hex2, hex1, hex0} !== {4{7'h10}}) begin errors++;
            $display("FAIL disp_9999 got %h %h %h %h exp 10 10 10 10",
                     hex3, hex2, hex1, hex0); end
        checks++;
        if (overflow !== 1'b0) begin errors++;
            $display("FAIL ovf_9999 got %b exp 0", overflow); end
        strobe(14'd10000, cyc);
        checks++;
        if ({hex3, hex2, hex1, hex0} !== {4{7'h3F}}) begin errors++;
            $display("FAIL disp_10000 got %h %h %h %h exp 3f 3f 3f 3f",
                     hex3, hex2, hex1, hex0); end
        checks++;
        if (overflow !== 1'b1) begin errors++;
            $display("FAIL ovf_10000 got %b exp 1", overflow); end
        strobe(14'd5, cyc);
        checks++;
        if (overflow !== 1'b0) begin errors++;
            $display("FAIL ovf_5 got %b exp 0", overflow); end
        checks++;
        if ({hex3, hex2, hex1, hex0} !== {LZ, LZ, LZ, 7'h12}) begin errors++;
            $display("FAIL disp_5 got %h %h %h %h exp %h %h %h 12",
                     hex3, hex2, hex1, hex0, LZ, LZ, LZ); end
    endtask

    task automatic test_ignore_busy;
        int cyc;
        @(posedge clock); #1;
        value = 14'd250; value_valid = 1'b1;
        @(posedge clock); #1;
        value_valid = 1'b0;
        cyc = 0;
        repeat (4) begin @(posedge clock); #1; cyc++; end
        value = 14'd777; value_valid = 1'b1;
        @(posedge clock); #1;
        value_valid = 1'b0;
        cyc++;
        while (busy === 1'b1 && cyc < 100) begin
            @(posedge clock); #1;
            cyc++;
        end
        checks++;
        if (cyc != 15) begin errors++;
            $display("FAIL busy_len_250 got %0d exp 15", cyc); end
        checks++;
        if ({hex3, hex2, hex1, hex0} !== {LZ, 7'h24, 7'h12, 7'h40}) begin errors++;
            $display("FAIL disp_250 got %h %h %h %h exp %h 24 12 40",
                     hex3, hex2, hex1, hex0, LZ); end
        repeat (20) @(posedge clock);
        #1;
        checks++;
        if (busy !== 1'b0 || hex0 !== 7'h40 || hex1 !== 7'h12) begin errors++;
            $display("FAIL no_queue_777 got busy=%b %h %h exp 0 40 12",
                     busy, hex0, hex1); end
    endtask

    task automatic test_reset_abort;
        int seen_bad;
        seen_bad = 0;
        @(posedge clock); #1;
        value = 14'd4321; value_valid = 1'b1;
        @(posedge clock); #1;
        value_valid = 1'b0;
        repeat (6) @(posedge clock);
        #1;
        reset = 1'b0;
        #1;
        checks++;
        if ({hex3, hex2, hex1, hex0} !== {LZ, LZ, LZ, 7'h40}) begin errors++;
            $display("FAIL abort_disp got %h %h %h %h exp %h %h %h 40",
                     hex3, hex2, hex1, hex0, LZ, LZ, LZ); end
        checks++;
        if (busy !== 1'b0 || overflow !== 1'b0) begin errors++;
            $display("FAIL abort_flags got busy=%b ovf=%b exp 0 0", busy, overflow); end
        @(negedge clock) reset = 1'b1;
        repeat (25) begin
            @(posedge clock); #1;
            if (hex3 === 7'h19 || hex0 === 7'h79) seen_bad++;
        end
        checks++;
        if (seen_bad != 0) begin errors++;
            $display("FAIL abort_leak got %0d cycles exp 0", seen_bad); end
        checks++;
        if ({hex3, hex2, hex1, hex0, busy} !== {LZ, LZ, LZ, 7'h40, 1'b0}) begin errors++;
            $display("FAIL abort_after got %h %h %h %h busy=%b exp reset display",
                     hex3, hex2, hex1, hex0, busy); end
    endtask

    initial begin
        test_reset();
        test_1234();
        test_zero();
        test_overflow();
        test_ignore_busy();
        test_reset_abort();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/volume_display.md
VOLUME_DISPLAY -- requirements
Module: volume_display

Interface
REQ-001 Parameter BIT_COUNT, default 14, SHALL set the width of the binary volume input, sized for 0..9999 mL.
REQ-002 Parameter DIGIT_COUNT, default 4, SHALL set the number of decimal digits converted and displayed.
REQ-003 Port clock, input, 1 bit, SHALL be the single system clock; all state changes on its rising edge.
REQ-004 Port reset, input, 1 bit, SHALL be an asynchronous, active-low reset.
REQ-005 Port value, input, BIT_COUNT bits, SHALL carry the unsigned binary volume in mL to display.
REQ-006 Port value_valid, input, 1 bit, SHALL be a one-cycle strobe requesting capture of value.
REQ-007 Port busy, output, 1 bit, SHALL be high while a conversion is in progress.
REQ-008 Port overflow, output, 1 bit, SHALL be high while the displayed request exceeds 10^DIGIT_COUNT - 1.
REQ-009 Ports hex0..hex3, outputs, 7 bits each, SHALL drive active-low seven-segment displays; bit0 = a ... bit6 = g; hex0 is the least significant digit.

Function
REQ-010 The block SHALL use a three-state FSM: IDLE, CONVERT and UPDATE.
REQ-011 In IDLE, value_valid = 1 SHALL latch value into a shift register, clear the BCD accumulator, load a bit counter with BIT_COUNT, assert busy and enter CONVERT on the same edge.
REQ-012 In CONVERT, each cycle SHALL run one double-dabble step: add 3 to every BCD nibble that is 5 or greater, then shift left one bit from the binary register into BCD nibble 0, and decrement the counter.
REQ-013 When the counter reaches 0, the FSM SHALL enter UPDATE; conversion SHALL take exactly BIT_COUNT cycles.
REQ-014 In UPDATE, the displays SHALL register the new segment codes, busy SHALL drop, and the FSM SHALL return to IDLE.
REQ-015 Latency: value_valid sampled at edge N SHALL produce new hex0..hex3 and busy = 0 visible after edge N + BIT_COUNT + 1.
REQ-016 A value_valid pulse while busy = 1 SHALL be ignored; it is neither queued nor able to corrupt the conversion in progress.
REQ-017 A captured value above 10^DIGIT_COUNT - 1 SHALL set overflow = 1 at UPDATE and drive every display with a dash (0x3F, segment g only).
REQ-018 A valid captured value SHALL clear overflow at UPDATE.
REQ-019 Segment codes SHALL be: 0 = 0x40, 1 = 0x79, 2 = 0x24, 3 = 0x30, 4 = 0x19, 5 = 0x12, 6 = 0x02, 7 = 0x78, 8 = 0x00, 9 = 0x10; blank = 0x7F.
REQ-020 The hex outputs SHALL change only on the UPDATE edge and SHALL hold steady during CONVERT, so there is no flicker.
REQ-021 The value 0 SHALL always display at least a "0" on hex0.

Reset
REQ-022 Asserting reset low SHALL immediately force state IDLE, busy = 0 and overflow = 0, clear the internal registers, and display the value 0 per REQ-021 and REQ-024.
REQ-023 Asserting reset during CONVERT SHALL abort the conversion; no partial result SHALL ever reach the displays.

Configuration
REQ-024 Macro LEADING_ZERO_BLANK_EN defined: every zero digit more significant than the highest nonzero digit SHALL show blank (0x7F), and hex0 is never blanked; macro undefined: all digits SHALL show numerically, including leading zeros.

Verification
REQ-025 Release reset, no stimulus -> hex0 = 0x40; hex1..3 = 0x7F with the macro, 0x40 without; busy = 0.
REQ-026 value = 1234, one-cycle value_valid -> busy high for exactly 15 cycles; then hex3..0 = 0x79, 0x24, 0x30, 0x19; overflow = 0.
REQ-027 value = 9999 -> all hex = 0x10; then value = 10000 -> all hex = 0x3F and overflow = 1; then value = 5 -> overflow = 0 and hex0 = 0x12.
REQ-028 value = 250 then a second value_valid with 777 at 5 cycles into the conversion -> display shows 250 (0x24, 0x12, 0x40, hex3 per macro); 777 is ignored.
REQ-029 Reset pulled low at cycle 7 of a conversion of 4321 -> outputs return to the reset display immediately, and 4321 never appears.
